// File: rtl/wishbone_nn_spike_sequencer.sv
// Wishbone-fed spike sequencer: tagged neuron/synapse IDs are queued in a FIFO and
// replayed as timed per-channel address pulses, with optional loop replay.
module wishbone_nn_spike_sequencer #(
    parameter int          ID_W      = 8,
    parameter int          NUM_CH    = 2,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_dat_i,
    input  logic [31:0]              wbs_adr_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [NUM_CH*ID_W-1:0]   syn_addr,
    output logic [NUM_CH-1:0]        syn_valid,
    output logic                     busy,
    output logic                     irq
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int EW   = CH_W + ID_W;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      tmr_q, tmr_d;
    logic [7:0]      gap_lat_q, gap_lat_d;
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, push_slot;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   head, push_entry;
    logic [CH_W-1:0] out_ch_q;
    logic [ID_W-1:0] out_id_q;

    logic            ack_q, req_we_q, irq_q, irq_d;
    logic [31:0]     rdat_q, rdat_d, rd_word;
    logic [2:0]      req_off_q;
    logic [31:0]     req_dat_q;
    logic            en_q, loop_q, ovf_q;
    logic [7:0]      plen_q, gap_q;
    logic [31:0]     ev_q;

    logic sel, req_new, wr_commit, push_req, ctrl_wr, stat_wr, ev_wr, flush;
    logic pop, repush, push_ok, drop, ev_inc, empty, full;
    logic unused_ok;

    assign sel     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:5] == ADDR_BASE[31:5]);
    assign req_new = sel & ~ack_q;

    // Bus side effects commit at the end of the ack cycle from the latched request.
    assign wr_commit = ack_q & req_we_q;
    assign push_req  = wr_commit && (req_off_q == 3'd0);
    assign ctrl_wr   = wr_commit && (req_off_q == 3'd1);
    assign stat_wr   = wr_commit && (req_off_q == 3'd2);
    assign ev_wr     = wr_commit && (req_off_q == 3'd3);
    assign flush     = ctrl_wr & req_dat_q[2];

    assign empty      = (cnt_q == '0);
    assign full       = (cnt_q == CW'(DEPTH));
    assign head       = mem_q[rptr_q];
    assign push_entry = {req_dat_q[16 +: CH_W], req_dat_q[0 +: ID_W]};

    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], req_dat_q};

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        gap_lat_d = gap_lat_q;
        pop       = 1'b0;
        ev_inc    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_q && !empty) begin
                    pop       = 1'b1;
                    state_d   = S_DRIVE;
                    tmr_d     = (plen_q == 8'd0) ? 8'd0 : plen_q - 8'd1;
                    gap_lat_d = gap_q;
                end
            end
            S_DRIVE: begin
                if (tmr_q == 8'd0) begin
                    ev_inc = 1'b1;
                    if (gap_lat_q != 8'd0) begin
                        state_d = S_GAP;
                        tmr_d   = gap_lat_q - 8'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            S_GAP: begin
                if (tmr_q == 8'd0) state_d = S_IDLE;
                else               tmr_d   = tmr_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            pop     = 1'b0;
        end
    end

    // A loop re-push takes the tail slot first; a coincident bus push lands behind it.
    always_comb begin
        repush    = pop & loop_q;
        push_ok   = push_req & ~full;
        drop      = push_req & full;
        push_slot = repush ? wptr_q + PW'(1) : wptr_q;
        wptr_d    = wptr_q + PW'(repush) + PW'(push_ok);
        rptr_d    = rptr_q + PW'(pop);
        cnt_d     = cnt_q + CW'(push_ok) - CW'(pop & ~loop_q);
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
        irq_d = en_q & ~loop_q & (cnt_q == CW'(1)) & (cnt_d == '0);
    end

    always_comb begin
        case (wbs_adr_i[4:2])
            3'd1:    rd_word = {8'd0, gap_q, plen_q, 5'd0, 1'b0, loop_q, en_q};
            3'd2:    rd_word = {13'd0, ovf_q, full, empty, 7'd0, 9'(cnt_q)};
            3'd3:    rd_word = ev_q;
            default: rd_word = '0;
        endcase
        rdat_d = (req_new && !wbs_we_i) ? rd_word : '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            req_we_q  <= 1'b0;
            rdat_q    <= '0;
            en_q      <= 1'b0;
            loop_q    <= 1'b0;
            plen_q    <= '0;
            gap_q     <= '0;
            ovf_q     <= 1'b0;
            ev_q      <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            gap_lat_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= req_new;
            req_we_q  <= req_new & wbs_we_i;
            rdat_q    <= rdat_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            gap_lat_q <= gap_lat_d;
            irq_q     <= irq_d;
            if (ctrl_wr) begin
                en_q   <= req_dat_q[0];
                loop_q <= req_dat_q[1];
                plen_q <= req_dat_q[15:8];
                gap_q  <= req_dat_q[23:16];
            end
            if (drop)                        ovf_q <= 1'b1;
            else if (stat_wr && req_dat_q[18]) ovf_q <= 1'b0;
            if (ev_wr)       ev_q <= '0;
            else if (ev_inc) ev_q <= ev_q + 32'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (req_new) begin
            req_off_q <= wbs_adr_i[4:2];
            req_dat_q <= wbs_dat_i;
        end
        if (repush)  mem_q[wptr_q]    <= head;
        if (push_ok) mem_q[push_slot] <= push_entry;
        if (pop)     {out_ch_q, out_id_q} <= head;
    end

    // Only the addressed channel carries the ID; out-of-range channels stay silent.
    always_comb begin
        syn_addr  = '0;
        syn_valid = '0;
        if (state_q == S_DRIVE) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (out_ch_q == CH_W'(c)) begin
                    syn_valid[c]              = 1'b1;
                    syn_addr[c*ID_W +: ID_W]  = out_id_q;
                end
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = ack_q ? rdat_q : '0;
    assign busy      = (state_q != S_IDLE);
    assign irq       = irq_q;

endmodule

// File: tb/tb_wishbone_nn_spike_sequencer.sv
// Directed bench for wishbone_nn_spike_sequencer with a pulse scoreboard.
module tb_wishbone_nn_spike_sequencer;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_PUSH = BASE + 32'h0;
    localparam logic [31:0] A_CTRL = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_EVC  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] dat_i = '0, adr = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic [23:0] syn_addr;
    logic [2:0]  syn_valid;
    logic        busy, irq;

    int n_chk  = 0;
    int n_fail = 0;
    int irq_cnt = 0;
    bit sb_en = 1'b1;

    typedef struct {
        logic [2:0]  v;
        logic [23:0] a;
        int          len;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    wishbone_nn_spike_sequencer #(
        .ID_W(8), .NUM_CH(3), .DEPTH(16), .ADDR_BASE(BASE)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .syn_addr(syn_addr), .syn_valid(syn_valid),
        .busy(busy), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic acked);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
        acked = 1'b0; rd = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                rd    = dat_o;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        acked;
        wb_xfer(1'b1, a, d, rd, acked);
        check(tag, {31'd0, acked}, 32'd1);
    endtask

    task automatic wb_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        acked;
        wb_xfer(1'b0, a, 32'd0, rd, acked);
        check({tag, "_ack"}, {31'd0, acked}, 32'd1);
        check(tag, rd, exp);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse monitor: records each completed pulse and scores it against the queue.
    initial begin
        int          run = 0;
        logic [2:0]  cur_v = '0;
        logic [23:0] cur_a = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (irq) irq_cnt++;
                if (syn_valid != '0) begin
                    if (run == 0) begin
                        cur_v = syn_valid;
                        cur_a = syn_addr;
                    end
                    run++;
                end else if (run != 0) begin
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("pulse_valid", {29'd0, cur_v}, {29'd0, e.v});
                        check("pulse_addr", {8'd0, cur_a}, {8'd0, e.a});
                        check("pulse_len", run, e.len);
                    end else if (sb_en) begin
                        check("pulse_unexpected", run, 0);
                    end
                    run = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          irq0;
        logic [31:0] rd;
        logic        acked;
        bit          drained;

        // Reset state
        step(3);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_valid", {29'd0, syn_valid}, 32'd0);
        check("rst_addr", {8'd0, syn_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        @(negedge clk); rst = 1'b0;
        wb_read("stat_reset", A_STAT, 32'h0001_0000);

        // Single pulse: len 3, gap 2, channel 1
        wb_write("ctrl_wr1", A_CTRL, 32'h0002_0301);
        irq0 = irq_cnt;
        sb_q.push_back('{v: 3'b010, a: 24'h00_5A00, len: 3});
        wb_write("push_5a", A_PUSH, 32'h0001_005A);
        step(1);
        check("lat_not_yet", {29'd0, syn_valid}, 32'd0);
        step(1);
        check("lat_valid", {29'd0, syn_valid}, 32'h2);
        check("lat_addr", {8'd0, syn_addr}, 32'h0000_5A00);
        check("lat_busy", {31'd0, busy}, 32'd1);
        wait_idle("idle_after_5a");
        check("irq_once", irq_cnt - irq0, 1);
        wb_read("evcnt_1", A_EVC, 32'd1);

        // Overflow with enable off
        wb_write("ctrl_off", A_CTRL, 32'h0000_0000);
        for (int i = 0; i < 17; i++) wb_write("push_fill", A_PUSH, 32'(i));
        wb_read("stat_full_ovf", A_STAT, 32'h0006_0010);
        wb_write("stat_w1c", A_STAT, 32'h0004_0000);
        wb_read("stat_ovf_clr", A_STAT, 32'h0002_0010);
        wb_read("ctrl_rd0", A_CTRL, 32'h0000_0000);
        wb_write("flush1", A_CTRL, 32'h0000_0004);
        wb_read("stat_flushed", A_STAT, 32'h0001_0000);

        // Loop replay of 1,2,3
        wb_write("ctrl_loop_cfg", A_CTRL, 32'h0000_0102);
        for (int i = 1; i <= 3; i++) wb_write("push_loop", A_PUSH, 32'(i));
        for (int r = 0; r < 2; r++)
            for (int i = 1; i <= 3; i++)
                sb_q.push_back('{v: 3'b001, a: 24'(i), len: 1});
        irq0 = irq_cnt;
        wb_write("ctrl_loop_en", A_CTRL, 32'h0000_0103);
        drained = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (sb_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        check("loop_drained", {31'd0, drained}, 32'd1);
        sb_en = 1'b0;
        wb_read("stat_loop_cnt", A_STAT, 32'h0000_0003);
        check("loop_no_irq", irq_cnt - irq0, 0);
        wb_write("flush2", A_CTRL, 32'h0000_0004);
        step(1);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_valid", {29'd0, syn_valid}, 32'd0);
        wb_read("stat_flush2", A_STAT, 32'h0001_0000);
        step(2);
        sb_q.delete();
        sb_en = 1'b1;

        // Out-of-range channel
        wb_write("evc_clr", A_EVC, 32'h1234_5678);
        wb_read("evcnt_0", A_EVC, 32'd0);
        wb_write("ctrl_inv", A_CTRL, 32'h0000_0201);
        irq0 = irq_cnt;
        wb_write("push_inv", A_PUSH, 32'h0003_0007);
        step(2);
        check("inv_valid", {29'd0, syn_valid}, 32'd0);
        check("inv_busy", {31'd0, busy}, 32'd1);
        wait_idle("idle_after_inv");
        wb_read("evcnt_inv", A_EVC, 32'd1);
        check("inv_irq", irq_cnt - irq0, 1);

        // Reset during DRIVE
        sb_en = 1'b0;
        wb_write("ctrl_long", A_CTRL, 32'h0000_0A01);
        wb_write("push_33", A_PUSH, 32'h0002_0033);
        step(2);
        check("long_valid", {29'd0, syn_valid}, 32'h4);
        check("long_addr", {8'd0, syn_addr}, 32'h0033_0000);
        wb_write("push_44", A_PUSH, 32'h0002_0044);
        @(negedge clk); rst = 1'b1;
        step(1);
        check("rstd_valid", {29'd0, syn_valid}, 32'd0);
        check("rstd_busy", {31'd0, busy}, 32'd0);
        check("rstd_ack", {31'd0, ack}, 32'd0);
        @(negedge clk); rst = 1'b0;
        sb_en = 1'b1;
        wb_read("stat_rstd", A_STAT, 32'h0001_0000);
        wb_read("ctrl_rstd", A_CTRL, 32'h0000_0000);
        wb_xfer(1'b0, 32'h4000_0000, 32'd0, rd, acked);
        check("unmapped_noack", {31'd0, acked}, 32'd0);
        check("unmapped_dat", rd, 32'd0);
        wb_read("reserved_rd", BASE + 32'h14, 32'd0);
        step(4);
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
